mem_access: RTL and testbench

Memory-access stage of the five-stage b-risc pipeline; sits between the EX/ME pipeline register and the `me` ME/WB register. It runs loads and stores against the data-memory port using a req/ack handshake. It size-aligns store data, and sign- or zero-extends load data. It stalls the upstream pipeline while a transaction is outstanding. Its result outputs feed `me` directly.

---
 rtl/mem_access_if.sv | 54 +++++
 rtl/mem_access.sv | 296 +++++++++++++++++++++++++++++
 tb/tb_mem_access.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_if.sv
// ---------------------------------------------------------------------------
// mem_access_if
//
// Data-memory port between the memory-access stage and data memory.
//
// Handshake (req/ack): the master raises dmem_req together with a stable
// dmem_we / dmem_addr / dmem_be / dmem_wdata and keeps all of them unchanged
// until the slave answers. The slave completes the transaction by raising
// dmem_ack for exactly the cycle in which it is done; for reads, dmem_rdata
// is valid only in that cycle. dmem_ack seen while dmem_req is low means
// nothing and is ignored. The master may withdraw dmem_req without an ack
// (abort or reset); the slave must then drop the transaction.
//
// Signals:
//   dmem_req    master -> slave  request
//   dmem_we     master -> slave  1 = write, 0 = read
//   dmem_addr   master -> slave  word-aligned address (bits [1:0] = 0)
//   dmem_be     master -> slave  little-endian byte enables
//   dmem_wdata  master -> slave  lane-replicated write data
//   dmem_ack    slave -> master  transaction completes this cycle
//   dmem_rdata  slave -> master  read data, valid with dmem_ack
// ---------------------------------------------------------------------------
interface mem_access_if #(
  parameter int ADDR_W = 32,
  parameter int WORD_W = 32
);
  logic              dmem_req;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [3:0]        dmem_be;
  logic [WORD_W-1:0] dmem_wdata;
  logic              dmem_ack;
  logic [WORD_W-1:0] dmem_rdata;

  modport master (
    output dmem_req,
    output dmem_we,
    output dmem_addr,
    output dmem_be,
    output dmem_wdata,
    input  dmem_ack,
    input  dmem_rdata
  );

  modport slave (
    input  dmem_req,
    input  dmem_we,
    input  dmem_addr,
    input  dmem_be,
    input  dmem_wdata,
    output dmem_ack,
    output dmem_rdata
  );
endinterface

// File: rtl/mem_access.sv
// ---------------------------------------------------------------------------
// mem_access
//
// Memory-access stage of the b-risc pipeline, between the EX/ME register and
// the ME/WB register. Runs loads and stores over the req/ack data-memory
// port, replicates store data across byte lanes, sign/zero-extends load data
// and stalls upstream while a bus transaction is outstanding.
//
// Ports:
//   clk, clr            clock, synchronous active-low reset
//   i_valid             EX/ME holds a live instruction
//   i_pc, i_instr       pc and instruction word
//   i_dest_src/_reg     writeback source select and destination register
//   i_alu_eval          ALU result, effective address for memory ops
//   i_mem_rd/_wr        load / store request (store wins if both)
//   i_mem_op            000 B, 001 H, 010 W, 100 BU, 101 HU, others = W
//   i_store_data        rs2 value for stores
//   dmem                data-memory port (master side)
//   o_stall             hold upstream stages
//   o_valid             outputs carry a committed instruction
//   o_pc .. o_alu_eval  results to the ME/WB register
//   o_misalign          misaligned access dropped this cycle
//   o_timeout           one-cycle pulse when a bus transaction is aborted
//   o_dbg_state         current FSM state (0 IDLE, 1 REQ, 2 DONE)
// ---------------------------------------------------------------------------
module mem_access #(
  parameter int ADDR_W         = 32,
  parameter int INSTR_W        = 32,
  parameter int DEST_SRC_W     = 2,
  parameter int REG_IDX_W      = 5,
  parameter int WORD_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  clr,

  input  logic                  i_valid,
  input  logic [ADDR_W-1:0]     i_pc,
  input  logic [INSTR_W-1:0]    i_instr,
  input  logic [DEST_SRC_W-1:0] i_dest_src,
  input  logic [REG_IDX_W-1:0]  i_dest_reg,
  input  logic [WORD_W-1:0]     i_alu_eval,
  input  logic                  i_mem_rd,
  input  logic                  i_mem_wr,
  input  logic [2:0]            i_mem_op,
  input  logic [WORD_W-1:0]     i_store_data,

  mem_access_if.master          dmem,

  output logic                  o_stall,
  output logic                  o_valid,
  output logic [ADDR_W-1:0]     o_pc,
  output logic [INSTR_W-1:0]    o_instr,
  output logic [DEST_SRC_W-1:0] o_dest_src,
  output logic [REG_IDX_W-1:0]  o_dest_reg,
  output logic [WORD_W-1:0]     o_alu_eval,
  output logic                  o_misalign,
  output logic                  o_timeout,
  output logic [1:0]            o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Wait-counter value of the last REQ cycle that may still see an ack.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  // ---------------------------------------------------------------------
  // State and capture registers
  // ---------------------------------------------------------------------
  state_t                state_q,    state_d;
  logic [7:0]            cnt_q,      cnt_d;
  logic                  req_q,      req_d;
  logic                  we_q,       we_d;
  logic [ADDR_W-1:0]     addr_q,     addr_d;
  logic [3:0]            be_q,       be_d;
  logic [WORD_W-1:0]     wdata_q,    wdata_d;
  logic [ADDR_W-1:0]     pc_q,       pc_d;
  logic [INSTR_W-1:0]    instr_q,    instr_d;
  logic [DEST_SRC_W-1:0] dest_src_q, dest_src_d;
  logic [REG_IDX_W-1:0]  dest_reg_q, dest_reg_d;
  logic [WORD_W-1:0]     eaddr_q,    eaddr_d;
  logic [2:0]            op_q,       op_d;
  logic                  load_q,     load_d;
  logic [WORD_W-1:0]     rdata_q,    rdata_d;
  logic                  timeout_q,  timeout_d;

  // ---------------------------------------------------------------------
  // Incoming-instruction decode
  // ---------------------------------------------------------------------
  logic              mem_op;
  logic              size_b;
  logic              size_h;
  logic              misaligned;
  logic [3:0]        be_in;
  logic [WORD_W-1:0] wdata_in;

  always_comb begin
    mem_op = i_valid && (i_mem_rd || i_mem_wr);
    size_b = (i_mem_op == 3'b000) || (i_mem_op == 3'b100);
    size_h = (i_mem_op == 3'b001) || (i_mem_op == 3'b101);

    // Every code that is neither a byte nor a halfword is a word access.
    if (size_h) begin
      misaligned = i_alu_eval[0];
    end else if (size_b) begin
      misaligned = 1'b0;
    end else begin
      misaligned = |i_alu_eval[1:0];
    end

    if (size_b) begin
      be_in    = 4'b0001 << i_alu_eval[1:0];
      wdata_in = {4{i_store_data[7:0]}};
    end else if (size_h) begin
      be_in    = i_alu_eval[1] ? 4'b1100 : 4'b0011;
      wdata_in = {2{i_store_data[15:0]}};
    end else begin
      be_in    = 4'b1111;
      wdata_in = i_store_data;
    end
  end

  // Pick the addressed lane out of the returned word and extend it.
  function automatic logic [WORD_W-1:0] load_extend(
    input logic [2:0]        op,
    input logic [1:0]        lane,
    input logic [WORD_W-1:0] rd
  );
    logic [7:0]  b;
    logic [15:0] h;
    b = rd[{lane, 3'b000} +: 8];
    h = lane[1] ? rd[31:16] : rd[15:0];
    case (op)
      3'b000:  return {{(WORD_W-8){b[7]}}, b};
      3'b100:  return {{(WORD_W-8){1'b0}}, b};
      3'b001:  return {{(WORD_W-16){h[15]}}, h};
      3'b101:  return {{(WORD_W-16){1'b0}}, h};
      default: return rd;
    endcase
  endfunction

  // ---------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    dest_src_d = dest_src_q;
    dest_reg_d = dest_reg_q;
    eaddr_d    = eaddr_q;
    op_d       = op_q;
    load_d     = load_q;
    rdata_d    = rdata_q;
    timeout_d  = 1'b0;

    o_stall    = 1'b0;
    o_valid    = 1'b0;
    o_misalign = 1'b0;
    o_pc       = i_pc;
    o_instr    = i_instr;
    o_dest_src = i_dest_src;
    o_dest_reg = i_dest_reg;
    o_alu_eval = i_alu_eval;

    case (state_q)
      S_IDLE: begin
        o_valid = i_valid;
        if (mem_op) begin
          o_valid = 1'b0;
          if (misaligned) begin
            // Dropped as a bubble; upstream is allowed to move on.
            o_misalign = 1'b1;
            o_dest_reg = '0;
          end else begin
            o_stall    = 1'b1;
            state_d    = S_REQ;
            cnt_d      = '0;
            req_d      = 1'b1;
            we_d       = i_mem_wr;
            addr_d     = {i_alu_eval[ADDR_W-1:2], 2'b00};
            be_d       = be_in;
            wdata_d    = wdata_in;
            pc_d       = i_pc;
            instr_d    = i_instr;
            dest_src_d = i_dest_src;
            dest_reg_d = i_dest_reg;
            eaddr_d    = i_alu_eval;
            op_d       = i_mem_op;
            load_d     = !i_mem_wr;
          end
        end
      end

      S_REQ: begin
        o_stall    = 1'b1;
        o_pc       = pc_q;
        o_instr    = instr_q;
        o_dest_src = dest_src_q;
        o_dest_reg = dest_reg_q;
        o_alu_eval = eaddr_q;
        if (dmem.dmem_ack) begin
          // An ack in the last allowed cycle still completes normally.
          state_d = S_DONE;
          req_d   = 1'b0;
          if (load_q) begin
            rdata_d = load_extend(op_q, eaddr_q[1:0], dmem.dmem_rdata);
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d   = S_DONE;
          req_d     = 1'b0;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      S_DONE: begin
        // timeout_q is only ever high during the DONE of an aborted op.
        o_valid    = !timeout_q;
        o_pc       = pc_q;
        o_instr    = instr_q;
        o_dest_src = dest_src_q;
        o_dest_reg = timeout_q ? '0 : dest_reg_q;
        o_alu_eval = load_q ? rdata_q : eaddr_q;
        state_d    = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      pc_q       <= '0;
      instr_q    <= '0;
      dest_src_q <= '0;
      dest_reg_q <= '0;
      eaddr_q    <= '0;
      op_q       <= '0;
      load_q     <= 1'b0;
      rdata_q    <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      dest_src_q <= dest_src_d;
      dest_reg_q <= dest_reg_d;
      eaddr_q    <= eaddr_d;
      op_q       <= op_d;
      load_q     <= load_d;
      rdata_q    <= rdata_d;
      timeout_q  <= timeout_d;
    end
  end

  // Bus outputs come straight from flops so they stay stable through REQ.
  assign dmem.dmem_req   = req_q;
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_be    = be_q;
  assign dmem.dmem_wdata = wdata_q;

  assign o_timeout   = timeout_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_mem_access.sv
// ---------------------------------------------------------------------------
// tb_mem_access
//
// Self-checking bench for mem_access (TIMEOUT_CYCLES = 4). Each instruction
// is described at transaction level (fields, ack cycle, read data); a small
// model derives from the access size what every output must be in each
// cycle of its life, and one compare routine checks the DUT every cycle.
// Directed cases pin the model with hand-computed literals; a random phase
// follows.
// ---------------------------------------------------------------------------
module tb_mem_access;
  localparam int TO = 4;

  // clock / reset
  logic clk = 1'b0;
  logic clr = 1'b0;
  always #5 clk = ~clk;

  // DUT inputs
  logic        i_valid;
  logic [31:0] i_pc;
  logic [31:0] i_instr;
  logic [1:0]  i_dest_src;
  logic [4:0]  i_dest_reg;
  logic [31:0] i_alu_eval;
  logic        i_mem_rd;
  logic        i_mem_wr;
  logic [2:0]  i_mem_op;
  logic [31:0] i_store_data;

  // DUT outputs
  logic        o_stall;
  logic        o_valid;
  logic [31:0] o_pc;
  logic [31:0] o_instr;
  logic [1:0]  o_dest_src;
  logic [4:0]  o_dest_reg;
  logic [31:0] o_alu_eval;
  logic        o_misalign;
  logic        o_timeout;
  logic [1:0]  o_dbg_state;

  mem_access_if #(.ADDR_W(32), .WORD_W(32)) bus ();

  mem_access #(
    .ADDR_W(32), .INSTR_W(32), .DEST_SRC_W(2), .REG_IDX_W(5), .WORD_W(32),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk          (clk),
    .clr          (clr),
    .i_valid      (i_valid),
    .i_pc         (i_pc),
    .i_instr      (i_instr),
    .i_dest_src   (i_dest_src),
    .i_dest_reg   (i_dest_reg),
    .i_alu_eval   (i_alu_eval),
    .i_mem_rd     (i_mem_rd),
    .i_mem_wr     (i_mem_wr),
    .i_mem_op     (i_mem_op),
    .i_store_data (i_store_data),
    .dmem         (bus),
    .o_stall      (o_stall),
    .o_valid      (o_valid),
    .o_pc         (o_pc),
    .o_instr      (o_instr),
    .o_dest_src   (o_dest_src),
    .o_dest_reg   (o_dest_reg),
    .o_alu_eval   (o_alu_eval),
    .o_misalign   (o_misalign),
    .o_timeout    (o_timeout),
    .o_dbg_state  (o_dbg_state)
  );

  // scoreboard counters
  int n_checks = 0;
  int n_errors = 0;

  // expected outputs for the current cycle
  logic        e_stall, e_valid, e_mis, e_to, e_req, e_we;
  logic [31:0] e_addr, e_wdata, e_pc, e_instr, e_alu;
  logic [3:0]  e_be;
  logic [1:0]  e_dsrc;
  logic [4:0]  e_dreg;
  logic        e_bus, e_wchk, e_res, e_alu_chk;

  // observation history (for literal checks)
  int          obs_stall = 0, obs_req = 0, obs_valid = 0, obs_to = 0, obs_mis = 0;
  int          s_stall, s_req, s_valid, s_to, s_mis;
  logic [31:0] last_alu, last_addr, last_wdata;
  logic [3:0]  last_be;
  logic        last_we;
  logic [1:0]  last_state;

  // random-phase variables
  logic        r_v, r_rd, r_wr;
  logic [2:0]  r_op;
  logic [31:0] r_alu, r_sd, r_rdata;
  int          r_kind, r_ack;

  // ---------------- model ----------------
  function automatic int sz(input logic [2:0] op);
    case (op)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      default:        return 4;
    endcase
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] op, input logic [1:0] lane);
    logic [3:0] m;
    m = 4'((1 << sz(op)) - 1);
    return 4'(m << lane);
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] op, input logic [31:0] sd);
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = sd[8*(i % sz(op)) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] op, input logic [1:0] lane,
                                         input logic [31:0] rd);
    int          s;
    logic [31:0] v, mask;
    s = sz(op);
    if (s == 4) return rd;
    mask = (s == 1) ? 32'h0000_00FF : 32'h0000_FFFF;
    v = (rd >> (8 * lane)) & mask;
    if ((op == 3'b000 || op == 3'b001) && v[8*s-1]) v = v | ~mask;
    return v;
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_outputs();
    check("o_stall",    32'(o_stall),    32'(e_stall));
    check("o_valid",    32'(o_valid),    32'(e_valid));
    check("o_misalign", 32'(o_misalign), 32'(e_mis));
    check("o_timeout",  32'(o_timeout),  32'(e_to));
    check("dmem_req",   32'(bus.dmem_req), 32'(e_req));
    if (e_bus) begin
      check("dmem_we",   32'(bus.dmem_we), 32'(e_we));
      check("dmem_addr", bus.dmem_addr,    e_addr);
      check("dmem_be",   32'(bus.dmem_be), 32'(e_be));
      if (e_wchk) check("dmem_wdata", bus.dmem_wdata, e_wdata);
    end
    if (e_res) begin
      check("o_pc",       o_pc,             e_pc);
      check("o_instr",    o_instr,          e_instr);
      check("o_dest_src", 32'(o_dest_src),  32'(e_dsrc));
      check("o_dest_reg", 32'(o_dest_reg),  32'(e_dreg));
    end
    if (e_alu_chk) check("o_alu_eval", o_alu_eval, e_alu);
    if (o_stall)    obs_stall++;
    if (o_valid)    begin obs_valid++; last_alu = o_alu_eval; end
    if (o_timeout)  obs_to++;
    if (o_misalign) obs_mis++;
    if (bus.dmem_req) begin
      obs_req++;
      last_addr = bus.dmem_addr; last_be = bus.dmem_be;
      last_wdata = bus.dmem_wdata; last_we = bus.dmem_we;
    end
    last_state = o_dbg_state;
  endtask

  task automatic tick();
    @(negedge clk);
    compare_outputs();
    @(posedge clk);
    #1;
  endtask

  task automatic snap();
    s_stall = obs_stall; s_req = obs_req; s_valid = obs_valid;
    s_to = obs_to; s_mis = obs_mis;
  endtask

  // ---------------- driver ----------------
  // ack_k: REQ cycle (1-based) in which the memory acks; 0 = never.
  task automatic run_op(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                        input logic [1:0] dsrc, input logic [4:0] dreg,
                        input logic [31:0] alu, input logic rd, input logic wr,
                        input logic [2:0] op, input logic [31:0] sd,
                        input int ack_k, input logic [31:0] rdata);
    logic mem, done;
    i_valid = v; i_pc = pc; i_instr = instr; i_dest_src = dsrc; i_dest_reg = dreg;
    i_alu_eval = alu; i_mem_rd = rd; i_mem_wr = wr; i_mem_op = op; i_store_data = sd;
    // stray acks outside REQ must be ignored
    bus.dmem_ack = 1'($urandom_range(0, 1)); bus.dmem_rdata = $urandom();
    mem = v && (rd || wr);
    e_stall = 0; e_valid = v; e_mis = 0; e_to = 0; e_req = 0; e_bus = 0; e_wchk = 0;
    e_res = 1; e_alu_chk = 1;
    e_pc = pc; e_instr = instr; e_dsrc = dsrc; e_dreg = dreg; e_alu = alu;
    if (!mem) begin tick(); return; end
    if ((int'(alu[1:0]) % sz(op)) != 0) begin
      e_valid = 0; e_mis = 1; e_dreg = 0;
      tick();
      return;
    end
    // acceptance cycle
    e_stall = 1; e_valid = 0; e_res = 0; e_alu_chk = 0;
    tick();
    // REQ cycles
    done = 0;
    e_req = 1; e_bus = 1; e_we = wr; e_addr = {alu[31:2], 2'b00};
    e_be = m_be(op, alu[1:0]); e_wdata = m_wdata(op, sd); e_wchk = wr;
    for (int j = 1; j <= TO && !done; j++) begin
      bus.dmem_ack   = (j == ack_k);
      bus.dmem_rdata = (j == ack_k) ? rdata : $urandom();
      tick();
      if (j == ack_k) done = 1;
    end
    // DONE cycle
    bus.dmem_ack = 1'($urandom_range(0, 1)); bus.dmem_rdata = $urandom();
    e_req = 0; e_bus = 0; e_wchk = 0; e_stall = 0;
    e_valid = done; e_to = !done; e_res = 1;
    e_dreg = done ? dreg : 5'd0;
    e_alu = wr ? alu : m_load(op, alu[1:0], rdata);
    e_alu_chk = done;
    tick();
  endtask

  // ---------------- main ----------------
  initial begin
    i_valid = 0; i_pc = 32'h40; i_instr = 32'h13; i_dest_src = 0; i_dest_reg = 5'd7;
    i_alu_eval = 32'h55; i_mem_rd = 0; i_mem_wr = 0; i_mem_op = 0; i_store_data = 0;
    bus.dmem_ack = 0; bus.dmem_rdata = 0;
    clr = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;

    // reset state: IDLE pass-through, bus registers cleared
    e_stall = 0; e_valid = 0; e_mis = 0; e_to = 0; e_req = 0;
    e_bus = 1; e_wchk = 1; e_we = 0; e_addr = 0; e_be = 0; e_wdata = 0;
    e_res = 1; e_alu_chk = 1; e_pc = 32'h40; e_instr = 32'h13; e_dsrc = 0;
    e_dreg = 5'd7; e_alu = 32'h55;
    tick();
    check("reset_state_idle", 32'(last_state), 32'd0);
    clr = 1;

    // non-memory pass-through
    run_op(1, 32'h1000, 32'h00A00093, 2'd0, 5'd1, 32'h0000_0123, 0, 0, 3'b010, 0, 1, 0);

    // LW 0x100, ack in REQ cycle 3
    snap();
    run_op(1, 32'h1004, 32'h10002083, 2'd1, 5'd1, 32'h100, 1, 0, 3'b010, 0, 3, 32'hDEADBEEF);
    check("lw_stall_cycles", 32'(obs_stall - s_stall), 32'd4);
    check("lw_req_cycles",   32'(obs_req - s_req),     32'd3);
    check("lw_valid_cycles", 32'(obs_valid - s_valid), 32'd1);
    check("lw_be",   32'(last_be), 32'hF);
    check("lw_addr", last_addr,    32'h100);
    check("lw_data", last_alu,     32'hDEADBEEF);

    // LB / LBU at 0x103, LHU at 0x102
    run_op(1, 32'h1008, 32'h10300083, 2'd1, 5'd2, 32'h103, 1, 0, 3'b000, 0, 1, 32'h80123456);
    check("lb_be",   32'(last_be), 32'b1000);
    check("lb_data", last_alu,     32'hFFFFFF80);
    run_op(1, 32'h100C, 32'h10304083, 2'd1, 5'd3, 32'h103, 1, 0, 3'b100, 0, 2, 32'h80123456);
    check("lbu_data", last_alu, 32'h00000080);
    run_op(1, 32'h1010, 32'h10205083, 2'd1, 5'd4, 32'h102, 1, 0, 3'b101, 0, 1, 32'h80123456);
    check("lhu_data", last_alu, 32'h00008012);

    // SH at 0x102
    run_op(1, 32'h1014, 32'h10101123, 2'd2, 5'd5, 32'h102, 0, 1, 3'b001, 32'h1234ABCD, 2, 0);
    check("sh_we",    32'(last_we), 32'd1);
    check("sh_be",    32'(last_be), 32'b1100);
    check("sh_wdata", last_wdata,   32'hABCDABCD);
    check("sh_addr",  last_addr,    32'h100);
    check("sh_alu",   last_alu,     32'h102);

    // misaligned LW at 0x101
    snap();
    run_op(1, 32'h1018, 32'h10102083, 2'd1, 5'd6, 32'h101, 1, 0, 3'b010, 0, 1, 0);
    check("mis_pulses",   32'(obs_mis - s_mis),     32'd1);
    check("mis_req",      32'(obs_req - s_req),     32'd0);
    check("mis_stall",    32'(obs_stall - s_stall), 32'd0);

    // timeout: ack never arrives
    snap();
    run_op(1, 32'h101C, 32'h20002083, 2'd1, 5'd7, 32'h200, 1, 0, 3'b010, 0, 0, 0);
    check("to_req_cycles",   32'(obs_req - s_req),     32'd4);
    check("to_pulses",       32'(obs_to - s_to),       32'd1);
    check("to_valid_cycles", 32'(obs_valid - s_valid), 32'd0);
    run_op(1, 32'h1020, 32'h00000013, 2'd0, 5'd0, 32'h0, 0, 0, 3'b000, 0, 1, 0);
    check("to_back_idle", 32'(last_state), 32'd0);

    // reset in the 2nd REQ cycle, late ack afterwards
    snap();
    i_valid = 1; i_pc = 32'h1024; i_instr = 32'h30002083; i_dest_src = 1; i_dest_reg = 5'd9;
    i_alu_eval = 32'h300; i_mem_rd = 1; i_mem_wr = 0; i_mem_op = 3'b010; bus.dmem_ack = 0;
    e_stall = 1; e_valid = 0; e_mis = 0; e_to = 0; e_req = 0; e_bus = 0; e_wchk = 0;
    e_res = 0; e_alu_chk = 0;
    tick();
    e_req = 1; e_bus = 1; e_we = 0; e_addr = 32'h300; e_be = 4'hF;
    tick();
    clr = 0;
    tick();
    clr = 1; i_valid = 0; bus.dmem_ack = 1; bus.dmem_rdata = 32'hCAFEF00D;
    e_stall = 0; e_req = 0; e_bus = 1; e_wchk = 1; e_we = 0; e_addr = 0; e_be = 0; e_wdata = 0;
    e_res = 1; e_alu_chk = 1; e_pc = 32'h1024; e_instr = 32'h30002083; e_dsrc = 1;
    e_dreg = 5'd9; e_alu = 32'h300;
    tick();
    check("rst_state_idle", 32'(last_state), 32'd0);
    bus.dmem_ack = 0;
    tick();
    check("rst_req_cycles",    32'(obs_req - s_req),     32'd2);
    check("rst_valid_never",   32'(obs_valid - s_valid), 32'd0);
    check("rst_timeout_never", 32'(obs_to - s_to),       32'd0);

    // random phase
    for (int n = 0; n < 250; n++) begin
      r_v    = ($urandom_range(0, 9) != 0);
      r_kind = $urandom_range(0, 3);
      r_rd   = (r_kind == 1) || (r_kind == 3);
      r_wr   = (r_kind >= 2);
      r_op   = 3'($urandom_range(0, 7));
      r_alu  = $urandom();
      if ($urandom_range(0, 1) == 1) r_alu[1:0] = 2'b00;
      r_sd    = $urandom();
      r_rdata = $urandom();
      r_ack   = $urandom_range(0, TO);
      run_op(r_v, $urandom(), $urandom(), 2'($urandom_range(0, 3)),
             5'($urandom_range(0, 31)), r_alu, r_rd, r_wr, r_op, r_sd, r_ack, r_rdata);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not complete, got time %0t expected finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
